// File: rtl/stage_if.sv
// stage_if: IF stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches over a req/ready handshake and drives the IF/ID register.
// Single delay-slot branches; redirects arriving on bubble cycles are parked
// until the outstanding fetch hands off.
// Optional macro IF_PERF_EN adds perf_fetch / perf_bubble counters.
module stage_if #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic        stall,
  input  logic [1:0]  pc_select,
  input  logic [31:0] pc_b,
  input  logic [31:0] pc_j,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
`ifdef IF_PERF_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble,
`endif
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    BUFFER = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            pend_valid, pend_valid_n;
  logic [XLEN-1:0] pend_target, pend_target_n;
  logic [XLEN-1:0] buf_word, buf_word_n;
  logic [XLEN-1:0] pc4_n, instr_n;
  logic            req_n;
  logic            avail, redirect, handoff, bubble;
  logic [XLEN-1:0] word, tgt, pc_plus4;

  // Redirect target, fetch availability and the word presented to ID
  always_comb begin
    unique case (pc_select)
      2'b01:   tgt = pc_b;
      2'b10:   tgt = jr_target;
      2'b11:   tgt = pc_j;
      default: tgt = pc_b;
    endcase
    redirect = ~stall & (pc_select != 2'b00);
    avail    = ((state == FETCH) & imem_ready) | (state == BUFFER);
    word     = (state == BUFFER) ? buf_word : imem_rdata;
    pc_plus4 = pc + XLEN'(4);
    handoff  = ~stall & avail;
    bubble   = ~stall & ~avail;
  end

  // Next-state and next IF/ID contents
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    buf_word_n    = buf_word;
    pc4_n         = pc4_id;
    instr_n       = instr_id;

    if (stall) begin
      // Park a completed word so the memory is released during the stall
      if ((state == FETCH) && imem_ready) begin
        buf_word_n = imem_rdata;
        state_n    = BUFFER;
      end
    end else if (avail) begin
      instr_n      = word;
      pc4_n        = pc_plus4;
      pc_n         = redirect ? tgt : (pend_valid ? pend_target : pc_plus4);
      pend_valid_n = 1'b0;
      state_n      = FETCH;
    end else begin
      instr_n = NOP_INSTR;
      if (redirect) begin
        pend_valid_n  = 1'b1;
        pend_target_n = tgt;
      end
    end

    // IDLE only lasts one cycle after reset
    if (state == IDLE) begin
      state_n = FETCH;
    end

    req_n = (state_n == FETCH);
  end

  // State, PC and IF/ID register
  always_ff @(posedge clock) begin
    if (reset_0) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      buf_word    <= '0;
      pc4_id      <= '0;
      instr_id    <= NOP_INSTR;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      buf_word    <= buf_word_n;
      pc4_id      <= pc4_n;
      instr_id    <= instr_n;
      imem_req    <= req_n;
    end
  end

  assign imem_addr = pc;

`ifdef IF_PERF_EN
  // Handoff and bubble event counters
  always_ff @(posedge clock) begin
    if (reset_0) begin
      perf_fetch  <= '0;
      perf_bubble <= '0;
    end else begin
      if (handoff) perf_fetch  <= perf_fetch + XLEN'(1);
      if (bubble)  perf_bubble <= perf_bubble + XLEN'(1);
    end
  end
`else
  logic unused_events;
  assign unused_events = handoff ^ bubble;
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed self-checking bench for stage_if.
// Memory model returns 32'hE000_0000 | addr, except 0x8 which holds 0x8C220004.
module tb_stage_if;

  logic        clock;
  logic        reset_0;
  logic        stall;
  logic [1:0]  pc_select;
  logic [31:0] pc_b, pc_j, jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc4_id, instr_id;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch, perf_bubble;
`endif

  int checks = 0;
  int errors = 0;

  stage_if dut (
    .clock      (clock),
    .reset_0    (reset_0),
    .stall      (stall),
    .pc_select  (pc_select),
    .pc_b       (pc_b),
    .pc_j       (pc_j),
    .jr_target  (jr_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
`ifdef IF_PERF_EN
    .perf_fetch (perf_fetch),
    .perf_bubble(perf_bubble),
`endif
    .pc4_id     (pc4_id),
    .instr_id   (instr_id)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h8) ? 32'h8C22_0004 : (32'hE000_0000 | a);
  endfunction

  // Instruction memory model
  always_comb imem_rdata = mem(imem_addr);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] instr_e,
                        input logic [31:0] pc4_e, input logic [31:0] addr_e);
    chk({tag, "_instr"}, instr_id, instr_e);
    chk({tag, "_pc4"}, pc4_id, pc4_e);
    chk({tag, "_addr"}, imem_addr, addr_e);
  endtask

  initial begin
    reset_0 = 1'b1; stall = 1'b0; pc_select = 2'b00;
    pc_b = '0; pc_j = '0; jr_target = '0; imem_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk_if("rst", 32'h0, 32'h0, 32'h0);

    // Release: IDLE one cycle, then sequential fetch
    reset_0 = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk_if("first", 32'h0, 32'h0, 32'h0);
    tick(); chk_if("seq0", mem(32'h0), 32'h4, 32'h4);
    tick(); chk_if("seq4", mem(32'h4), 32'h8, 32'h8);

    // Stall for 3 cycles while 0x8 completes
    stall = 1'b1;
    tick();
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk_if("stall1", mem(32'h4), 32'h8, 32'h8);
    tick(); tick();
    chk_if("stall3", mem(32'h4), 32'h8, 32'h8);
    stall = 1'b0;
    tick();
    chk_if("unstall", 32'h8C22_0004, 32'hC, 32'hC);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    tick(); chk_if("seqC", mem(32'hC), 32'h10, 32'h10);

    // Two wait states at 0x10
    imem_ready = 1'b0;
    tick(); chk_if("wait1", 32'h0, 32'h10, 32'h10);
    tick(); chk_if("wait2", 32'h0, 32'h10, 32'h10);
    imem_ready = 1'b1;
    tick(); chk_if("seq10", mem(32'h10), 32'h14, 32'h14);
    tick(); tick(); tick();
    chk_if("seq1C", mem(32'h1C), 32'h20, 32'h20);
    tick(); chk_if("beq_in_id", mem(32'h20), 32'h24, 32'h24);

    // Branch with delay slot
    pc_select = 2'b01; pc_b = 32'h100;
    tick(); chk_if("delay_slot", mem(32'h24), 32'h28, 32'h100);
    pc_select = 2'b00;
    tick(); chk_if("br_target", mem(32'h100), 32'h104, 32'h104);

    // Jump back to 0x20
    pc_select = 2'b11; pc_j = 32'h20;
    tick(); chk_if("jump", mem(32'h104), 32'h108, 32'h20);
    pc_select = 2'b00;
    tick(); chk_if("jr_in_id", mem(32'h20), 32'h24, 32'h24);

    // jr on a bubble cycle is parked until 0x24 completes
    imem_ready = 1'b0; pc_select = 2'b10; jr_target = 32'h200;
    tick(); chk_if("jr_bubble", 32'h0, 32'h24, 32'h24);
    imem_ready = 1'b1; pc_select = 2'b00;
    tick(); chk_if("jr_pend", mem(32'h24), 32'h28, 32'h200);
    tick(); chk_if("jr_target", mem(32'h200), 32'h204, 32'h204);

    // Redirect during stall is ignored
    stall = 1'b1; imem_ready = 1'b0; pc_select = 2'b01; pc_b = 32'h300;
    tick(); chk_if("stall_redir", mem(32'h200), 32'h204, 32'h204);
    stall = 1'b0; imem_ready = 1'b1; pc_select = 2'b00;
    tick(); chk_if("no_redir", mem(32'h204), 32'h208, 32'h208);

    // Reset during an outstanding fetch with ready high
    reset_0 = 1'b1;
    tick();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk_if("midrst", 32'h0, 32'h0, 32'h0);
    reset_0 = 1'b0;
    tick();
    chk_if("rerun", 32'h0, 32'h0, 32'h0);

    // pc+4 wraps at 2^32
    pc_select = 2'b11; pc_j = 32'hFFFF_FFFC;
    tick(); chk_if("to_top", mem(32'h0), 32'h4, 32'hFFFF_FFFC);
    pc_select = 2'b00;
    tick(); chk_if("wrap", mem(32'hFFFF_FFFC), 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
